bcd_scan_mux: RTL

Time-multiplexed digit scanner that sits directly upstream of the BCD-to-7-segment decoder. It holds a multi-digit packed-BCD value and presents one digit at a time on the decoder's 4-bit input (A..D). It drives a one-hot digit-enable bus so a single decoder serves a multi-digit common-segment display. Value updates are frame-synchronous to avoid tearing, and leading zeros are optionally blanked.

---
 rtl/bcd_scan_mux.sv | 129 ++++++++++++
 1 files changed

// File: rtl/bcd_scan_mux.sv
// Time-multiplexed digit scanner feeding a BCD-to-7-segment decoder: holds a packed-BCD
// value, scans one digit per slot, swaps in new values only at frame boundaries.
module bcd_scan_mux #(
   parameter int DIGITS   = 4,
   parameter int DIV      = 50000,
   parameter bit BLANK_LZ = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load,
   input  logic [4*DIGITS-1:0]   value,
   output logic                  A,
   output logic                  B,
   output logic                  C,
   output logic                  D,
   output logic [DIGITS-1:0]     digit_en,
   output logic                  blank,
   output logic                  load_ack,
   output logic                  err_bcd
);

   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
   localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

   logic [CW-1:0]         cnt_q, cnt_d;
   logic [IW-1:0]         idx_q, idx_d;
   logic [4*DIGITS-1:0]   disp_q, disp_d;
   logic [4*DIGITS-1:0]   shadow_q, shadow_d;
   logic                  pending_q, pending_d;
   logic                  upd_q, upd_d;
   logic                  tick, frame;

   logic [3:0]            nib_q, nib_d;
   logic [DIGITS-1:0]     en_q, en_d;
   logic                  blank_q, blank_d;
   logic                  ack_q, ack_d;
   logic                  err_q, err_d;

   always_comb begin
      tick      = (cnt_q == CNT_LAST);
      frame     = tick && (idx_q == IDX_LAST);
      cnt_d     = tick ? '0 : cnt_q + 1'b1;
      idx_d     = idx_q;
      if (tick) begin
         idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
      end
      shadow_d  = load ? value : shadow_q;
      pending_d = pending_q | load;
      disp_d    = disp_q;
      upd_d     = 1'b0;
      // A load in the frame cycle bypasses the shadow so it is shown this frame.
      if (frame) begin
         upd_d     = load | pending_q;
         pending_d = 1'b0;
         if (load) begin
            disp_d = value;
         end else if (pending_q) begin
            disp_d = shadow_q;
         end
      end
   end

   logic [3:0]          dig [DIGITS];
   logic [DIGITS-1:0]   bad;
   logic [DIGITS-1:0]   slot_blank;
   logic [DIGITS:1]     upper_zero;

   assign upper_zero[DIGITS] = 1'b1;

   genvar gi;
   generate
      for (gi = 0; gi < DIGITS; gi++) begin : g_slot
         assign dig[gi] = disp_q[4*gi +: 4];
         assign bad[gi] = (dig[gi] > 4'd9);
         if (gi == 0) begin : g_lsd
            assign slot_blank[gi] = bad[gi];
         end else begin : g_upper
            // upper_zero[gi]: digits gi..DIGITS-1 are all zero
            assign upper_zero[gi]  = (dig[gi] == 4'd0) && upper_zero[gi+1];
            assign slot_blank[gi]  = bad[gi] | (BLANK_LZ && upper_zero[gi]);
         end
      end
   endgenerate

   always_comb begin
      blank_d = slot_blank[idx_q];
      nib_d   = blank_d ? 4'd0 : dig[idx_q];
      en_d    = blank_d ? '0 : (DIGITS'(1) << idx_q);
      ack_d   = upd_q;
      err_d   = |bad;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q     <= '0;
         idx_q     <= '0;
         disp_q    <= '0;
         shadow_q  <= '0;
         pending_q <= 1'b0;
         upd_q     <= 1'b0;
         nib_q     <= 4'd0;
         en_q      <= DIGITS'(1);
         blank_q   <= 1'b0;
         ack_q     <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         idx_q     <= idx_d;
         disp_q    <= disp_d;
         shadow_q  <= shadow_d;
         pending_q <= pending_d;
         upd_q     <= upd_d;
         nib_q     <= nib_d;
         en_q      <= en_d;
         blank_q   <= blank_d;
         ack_q     <= ack_d;
         err_q     <= err_d;
      end
   end

   assign {A, B, C, D} = nib_q;
   assign digit_en     = en_q;
   assign blank        = blank_q;
   assign load_ack     = ack_q;
   assign err_bcd      = err_q;

endmodule
